// File: rtl/tact_event_decoder_if.sv
// rtl/tact_event_decoder_if.sv - button pin and event pulse bundle for tact_event_decoder
// master drives the raw pin and consumes events; slave is the decoder.
interface tact_event_decoder_if;
  logic Tact1;
  logic PRESSED;
  logic SHORT_PULSE;
  logic LONG_PULSE;
  logic DOUBLE_PULSE;

  modport master (
    output Tact1,
    input  PRESSED,
    input  SHORT_PULSE,
    input  LONG_PULSE,
    input  DOUBLE_PULSE
  );

  modport slave (
    input  Tact1,
    output PRESSED,
    output SHORT_PULSE,
    output LONG_PULSE,
    output DOUBLE_PULSE
  );
endinterface

// File: rtl/tact_event_decoder.sv
// rtl/tact_event_decoder.sv - Tact1 synchronizer, debouncer and short/long/double click classifier
// Optional double-click detection is built when TACT_DOUBLE_CLICK_EN is defined.
module tact_event_decoder #(
  parameter int unsigned DEB_CNT  = 240000,
  parameter int unsigned W_DEB    = 18,
  parameter int unsigned LONG_CNT = 12000000,
  parameter int unsigned DBL_CNT  = 7200000,
  parameter int unsigned W_HOLD   = 24
) (
  input  logic                  CLK_24MHz,
  input  logic                  RST,
  tact_event_decoder_if.slave   bus
);

  localparam logic [W_DEB-1:0]  DEB_LAST  = W_DEB'(DEB_CNT - 1);
  localparam logic [W_HOLD-1:0] LONG_LAST = W_HOLD'(LONG_CNT - 1);

`ifdef TACT_DOUBLE_CLICK_EN
  localparam logic [W_HOLD-1:0] DBL_LAST  = W_HOLD'(DBL_CNT - 1);
  localparam int unsigned       EVT_W     = 3;
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRESS  = 3'd1,
    ST_LONG   = 3'd2,
    ST_WAIT2  = 3'd3,
    ST_PRESS2 = 3'd4
  } state_t;
`else
  localparam int unsigned       EVT_W     = 2;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRESS = 2'd1,
    ST_LONG  = 2'd2
  } state_t;
`endif

  logic [1:0]       sync_q;
  logic             s;
  logic             d;
  logic [W_DEB-1:0] dcnt;

  always_ff @(posedge CLK_24MHz) begin
    if (RST) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], bus.Tact1};
    end
  end

  assign s = sync_q[1];

  // Any disagreement must persist DEB_CNT consecutive cycles before d follows s.
  always_ff @(posedge CLK_24MHz) begin
    if (RST) begin
      d    <= 1'b1;
      dcnt <= '0;
    end else if (s == d) begin
      dcnt <= '0;
    end else if (dcnt == DEB_LAST) begin
      d    <= s;
      dcnt <= '0;
    end else begin
      dcnt <= dcnt + 1'b1;
    end
  end

  assign bus.PRESSED = ~d;

  state_t            state_q, state_d;
  logic [W_HOLD-1:0] hcnt_q, hcnt_d;
  logic [EVT_W-1:0]  evt_d, evt_q, pulse_q;

  always_ff @(posedge CLK_24MHz) begin
    if (RST) begin
      state_q <= ST_IDLE;
      hcnt_q  <= '0;
      evt_q   <= '0;
      pulse_q <= '0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      evt_q   <= evt_d;
      pulse_q <= evt_q;
    end
  end

  // evt bits: [0] short, [1] long, [2] double
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    evt_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (!d) begin
          hcnt_d  = '0;
          state_d = ST_PRESS;
        end
      end
      ST_PRESS: begin
        if (d) begin
`ifdef TACT_DOUBLE_CLICK_EN
          hcnt_d   = '0;
          state_d  = ST_WAIT2;
`else
          evt_d[0] = 1'b1;
          state_d  = ST_IDLE;
`endif
        end else if (hcnt_q == LONG_LAST) begin
          evt_d[1] = 1'b1;
          state_d  = ST_LONG;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      ST_LONG: begin
        if (d) begin
          state_d = ST_IDLE;
        end
      end
`ifdef TACT_DOUBLE_CLICK_EN
      ST_WAIT2: begin
        if (!d) begin
          state_d = ST_PRESS2;
        end else if (hcnt_q == DBL_LAST) begin
          evt_d[0] = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      ST_PRESS2: begin
        if (d) begin
          evt_d[2] = 1'b1;
          state_d  = ST_IDLE;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.SHORT_PULSE  = pulse_q[0];
  assign bus.LONG_PULSE   = pulse_q[1];
`ifdef TACT_DOUBLE_CLICK_EN
  assign bus.DOUBLE_PULSE = pulse_q[2];
`else
  assign bus.DOUBLE_PULSE = 1'b0;
`endif

endmodule

// File: tb/tb_tact_event_decoder.sv
// tb/tb_tact_event_decoder.sv - directed scoreboard bench for tact_event_decoder
// Expected pulses are queued with their cycle when the button is driven.
module tb_tact_event_decoder;

  localparam int DEB = 4;
  localparam int LNG = 20;
  localparam int DBL = 10;
`ifdef TACT_DOUBLE_CLICK_EN
  localparam int SHORT_DLY = DBL + 2;
`else
  localparam int SHORT_DLY = 2;
`endif
  localparam int K_SHORT  = 1;
  localparam int K_LONG   = 2;
  localparam int K_DOUBLE = 4;

  typedef struct {
    int kind;
    int at;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;
  ev_t  expq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tact_event_decoder_if bus();

  tact_event_decoder #(
    .DEB_CNT  (DEB),
    .W_DEB    (18),
    .LONG_CNT (LNG),
    .DBL_CNT  (DBL),
    .W_HOLD   (24)
  ) dut (
    .CLK_24MHz (clk),
    .RST       (rst),
    .bus       (bus)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_ev(input int kind, input int at);
    ev_t e;
    e.kind = kind;
    e.at   = at;
    expq.push_back(e);
  endtask

  always @(negedge clk) begin : mon
    ev_t e;
    int  kind;
    kind = int'({bus.DOUBLE_PULSE, bus.LONG_PULSE, bus.SHORT_PULSE});
    if (!rst && kind != 0) begin
      if (expq.size() == 0) begin
        check("unexpected_pulse", kind, 0);
      end else begin
        e = expq.pop_front();
        check("pulse_kind", kind, e.kind);
        check("pulse_cycle", cyc, e.at);
      end
    end
  end

  initial begin
    int k0;
    int r;
    int seen;

    // reset with the button already held
    bus.Tact1 = 1'b0;
    rst = 1'b1;
    tick(3);
    check("rst_pressed", int'(bus.PRESSED), 0);
    check("rst_short", int'(bus.SHORT_PULSE), 0);
    check("rst_long", int'(bus.LONG_PULSE), 0);
    check("rst_double", int'(bus.DOUBLE_PULSE), 0);
    rst = 1'b0;
    r = cyc;
    tick(5);
    check("rst_pressed_early", int'(bus.PRESSED), 0);
    tick(1);
    check("rst_pressed_rise", int'(bus.PRESSED), 1);
    bus.Tact1 = 1'b1;
    expect_ev(K_SHORT, r + 12 + SHORT_DLY);
    tick(30);
    check("rst_release_done", expq.size(), 0);

    // bounce: 2-cycle toggles never satisfy the debounce window
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      bus.Tact1 = (i % 2 == 0) ? 1'b0 : 1'b1;
      repeat (2) begin
        @(negedge clk);
        if (bus.PRESSED) seen = 1;
      end
    end
    bus.Tact1 = 1'b1;
    tick(10);
    check("bounce_seen_pressed", seen, 0);
    check("bounce_pressed", int'(bus.PRESSED), 0);

    // short press: 10 cycles low
    k0 = cyc;
    expect_ev(K_SHORT, k0 + 16 + SHORT_DLY);
    bus.Tact1 = 1'b0;
    tick(6);
    check("short_pressed", int'(bus.PRESSED), 1);
    tick(4);
    bus.Tact1 = 1'b1;
    tick(6);
    check("short_released", int'(bus.PRESSED), 0);
    tick(24);
    check("short_done", expq.size(), 0);

    // long press: 40 cycles low, pulse 21 cycles after ST_PRESS entry
    k0 = cyc;
    expect_ev(K_LONG, k0 + 28);
    bus.Tact1 = 1'b0;
    tick(40);
    bus.Tact1 = 1'b1;
    tick(30);
    check("long_done", expq.size(), 0);
    check("long_released", int'(bus.PRESSED), 0);

    // reset in the middle of a press
    k0 = cyc;
    bus.Tact1 = 1'b0;
    tick(10);
    rst = 1'b1;
    tick(2);
    check("midrst_pressed", int'(bus.PRESSED), 0);
    rst = 1'b0;
    r = cyc;
    tick(5);
    check("midrst_early", int'(bus.PRESSED), 0);
    tick(1);
    check("midrst_redetect", int'(bus.PRESSED), 1);
    bus.Tact1 = 1'b1;
    expect_ev(K_SHORT, r + 12 + SHORT_DLY);
    tick(30);
    check("midrst_done", expq.size(), 0);

`ifdef TACT_DOUBLE_CLICK_EN
    // double click: low 8, high 8, low 8
    k0 = cyc;
    expect_ev(K_DOUBLE, k0 + 32);
    bus.Tact1 = 1'b0;
    tick(8);
    bus.Tact1 = 1'b1;
    tick(8);
    bus.Tact1 = 1'b0;
    tick(8);
    bus.Tact1 = 1'b1;
    tick(30);
    check("double_done", expq.size(), 0);

    // gap timeout: single click reported 11 cycles after ST_WAIT2 entry
    k0 = cyc;
    expect_ev(K_SHORT, k0 + 26);
    bus.Tact1 = 1'b0;
    tick(8);
    bus.Tact1 = 1'b1;
    tick(30);
    check("gap_timeout_done", expq.size(), 0);

    // second press seen exactly at hcnt == DBL-1 wins over the timeout
    k0 = cyc;
    expect_ev(K_DOUBLE, k0 + 34);
    bus.Tact1 = 1'b0;
    tick(8);
    bus.Tact1 = 1'b1;
    tick(10);
    bus.Tact1 = 1'b0;
    tick(8);
    bus.Tact1 = 1'b1;
    tick(30);
    check("gap_edge_done", expq.size(), 0);
`endif

    tick(5);
    check("final_queue_empty", expq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
